// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero, canonical NaN, exception flags and a global-stall valid/ready handshake.
module fp_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);

   localparam int N    = MAN_W + 4;
   localparam int LZ_W = $clog2(N + 1);
   localparam int E_W  = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [E_W-1:0]   SH_MAX   = E_W'(MAN_W + 3);
   localparam logic [E_W-1:0]   E_MAX    = E_W'((1 << EXP_W) - 1);

   function automatic logic [N-1:0] align_shr(input logic [N-1:0] v, input logic [E_W-1:0] d);
      logic [N-1:0] lost_mask;
      if (d >= SH_MAX) return {{(N-1){1'b0}}, 1'b1};
      lost_mask = ~({N{1'b1}} << d);
      return (v >> d) | {{(N-1){1'b0}}, |(v & lost_mask)};
   endfunction

   function automatic logic [LZ_W-1:0] lzc(input logic [N-1:0] v);
      logic [LZ_W-1:0] cnt;
      logic            found;
      cnt   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      cnt   = cnt + 1'b1;
         end
      end
      return cnt;
   endfunction

   // Layout {hidden, mantissa, guard, round, sticky}
   function automatic logic rne_inc(input logic [N-1:0] m);
      return m[2] & (m[3] | m[1] | m[0]);
   endfunction

   logic en;
   logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q;
   logic spec_p1_q, spec_p1_d, spec_p2_q, spec_p2_d;
   logic [W-1:0] spec_res_p1_q, spec_res_p1_d, spec_res_p2_q, spec_res_p2_d;
   logic [3:0] spec_flg_p1_q, spec_flg_p1_d, spec_flg_p2_q, spec_flg_p2_d;
   logic sgn_p1_q, sgn_p1_d, sgn_p2_q, sgn_p2_d;
   logic [EXP_W-1:0] exp_p1_q, exp_p1_d, exp_p2_q, exp_p2_d;
   logic [N-1:0] mx_p1_q, mx_p1_d, my_p1_q, my_p1_d;
   logic esub_p1_q, esub_p1_d;
   logic [N:0] sum_p2_q, sum_p2_d;
   logic [W-1:0] res_p3_q, res_p3_d;
   logic [3:0] flg_p3_q, flg_p3_d;

   assign en        = !vld_p3_q | out_ready;
   assign in_ready  = en;
   assign out_valid = vld_p3_q;
   assign result    = res_p3_q;
   assign flags     = flg_p3_q;

   // Stage 1: unpack, classify specials, swap so X has the larger magnitude, align Y
   logic sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [EXP_W-1:0] ea, eb, ex, ey;
   logic [MAN_W-1:0] ma, mb;

   always_comb begin
      sa     = a[W-1];
      ea     = a[W-2:MAN_W];
      ma     = a[MAN_W-1:0];
      sb     = b[W-1] ^ sub;
      eb     = b[W-2:MAN_W];
      mb     = b[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == EXP_ONES) && (ma == '0);
      b_inf  = (eb == EXP_ONES) && (mb == '0);
      a_nan  = (ea == EXP_ONES) && (ma != '0);
      b_nan  = (eb == EXP_ONES) && (mb != '0);
      swap   = {eb, mb} > {ea, ma};

      spec_p1_d     = 1'b1;
      spec_res_p1_d = '0;
      spec_flg_p1_d = '0;
      if (a_nan || b_nan) begin
         spec_res_p1_d = QNAN;
      end else if (a_inf && b_inf) begin
         if (sa != sb) begin
            spec_res_p1_d = QNAN;
            spec_flg_p1_d = 4'b1000;
         end else begin
            spec_res_p1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
         end
      end else if (a_inf) begin
         spec_res_p1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_res_p1_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         spec_res_p1_d = {sa & sb, {(W-1){1'b0}}};
      end else if (a_zero) begin
         spec_res_p1_d = {sb, eb, mb};
      end else if (b_zero) begin
         spec_res_p1_d = {sa, ea, ma};
      end else begin
         spec_p1_d = 1'b0;
      end

      ex        = swap ? eb : ea;
      ey        = swap ? ea : eb;
      sgn_p1_d  = swap ? sb : sa;
      exp_p1_d  = ex;
      esub_p1_d = sa ^ sb;
      mx_p1_d   = {1'b1, (swap ? mb : ma), 3'b000};
      my_p1_d   = align_shr({1'b1, (swap ? ma : mb), 3'b000},
                            {{(E_W-EXP_W){1'b0}}, ex} - {{(E_W-EXP_W){1'b0}}, ey});
      vld_p1_d  = in_valid;
   end

   // Stage 2: magnitude add or subtract, carry-out kept
   always_comb begin
      vld_p2_d      = vld_p1_q;
      spec_p2_d     = spec_p1_q;
      spec_res_p2_d = spec_res_p1_q;
      spec_flg_p2_d = spec_flg_p1_q;
      sgn_p2_d      = sgn_p1_q;
      exp_p2_d      = exp_p1_q;
      sum_p2_d      = esub_p1_q ? ({1'b0, mx_p1_q} - {1'b0, my_p1_q})
                                : ({1'b0, mx_p1_q} + {1'b0, my_p1_q});
   end

   // Stage 3: normalize, round to nearest even, overflow/underflow, result select
   logic [E_W-1:0] ex_e, lz_e, sh, e_n, e_f;
   logic [N-1:0]   m_n;
   logic [MAN_W+1:0] m_r;
   logic [MAN_W-1:0] frac;
   logic uf, inx;

   always_comb begin
      ex_e = {{(E_W-EXP_W){1'b0}}, exp_p2_q};
      lz_e = {{(E_W-LZ_W){1'b0}}, lzc(sum_p2_q[N-1:0])};
      sh   = '0;
      uf   = 1'b0;
      if (sum_p2_q[N]) begin
         m_n = {sum_p2_q[N:2], sum_p2_q[1] | sum_p2_q[0]};
         e_n = ex_e + 1'b1;
      end else begin
         uf  = (lz_e >= ex_e);
         sh  = uf ? (ex_e - 1'b1) : lz_e;
         m_n = sum_p2_q[N-1:0] << sh;
         e_n = ex_e - sh;
      end
      inx = |m_n[2:0];
      m_r = {1'b0, m_n[N-1:3]} + {{(MAN_W+1){1'b0}}, rne_inc(m_n)};
      if (m_r[MAN_W+1]) begin
         frac = m_r[MAN_W:1];
         e_f  = e_n + 1'b1;
      end else begin
         frac = m_r[MAN_W-1:0];
         e_f  = e_n;
      end

      res_p3_d = res_p3_q;
      flg_p3_d = flg_p3_q;
      if (en && vld_p2_q) begin
         if (spec_p2_q) begin
            res_p3_d = spec_res_p2_q;
            flg_p3_d = spec_flg_p2_q;
         end else if (sum_p2_q == '0) begin
            res_p3_d = '0;
            flg_p3_d = 4'b0000;
         end else if (uf) begin
            res_p3_d = {sgn_p2_q, {(W-1){1'b0}}};
            flg_p3_d = 4'b0011;
         end else if (e_f >= E_MAX) begin
            res_p3_d = {sgn_p2_q, EXP_ONES, {MAN_W{1'b0}}};
            flg_p3_d = 4'b0101;
         end else begin
            res_p3_d = {sgn_p2_q, e_f[EXP_W-1:0], frac};
            flg_p3_d = {3'b000, inx};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         res_p3_q <= '0;
         flg_p3_q <= '0;
      end else begin
         if (en) begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p2_q;
         end
         res_p3_q <= res_p3_d;
         flg_p3_q <= flg_p3_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         spec_p1_q     <= spec_p1_d;
         spec_res_p1_q <= spec_res_p1_d;
         spec_flg_p1_q <= spec_flg_p1_d;
         sgn_p1_q      <= sgn_p1_d;
         exp_p1_q      <= exp_p1_d;
         mx_p1_q       <= mx_p1_d;
         my_p1_q       <= my_p1_d;
         esub_p1_q     <= esub_p1_d;
         spec_p2_q     <= spec_p2_d;
         spec_res_p2_q <= spec_res_p2_d;
         spec_flg_p2_q <= spec_flg_p2_d;
         sgn_p2_q      <= sgn_p2_d;
         exp_p2_q      <= exp_p2_d;
         sum_p2_q      <= sum_p2_d;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (binary32): arithmetic vectors, specials,
// back-pressure ordering and mid-flight reset, all with hand-computed expectations.
module tb_fp_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [3:0]  flags;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   fp_addsub_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic [31:0] er, input logic [3:0] ef);
      int n;
      a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         step();
         n++;
      end
      chk({tag, " latency"}, n, 32'd3);
      chk({tag, " result"}, result, er);
      chk({tag, " flags"}, {28'b0, flags}, {28'b0, ef});
   endtask

   logic [31:0] st_a [0:5];
   logic [31:0] st_b [0:5];
   logic        st_s [0:5];
   logic [31:0] st_r [0:5];
   logic [31:0] got_q [$];

   initial begin
      int ni, no, cyc, seen;
      logic acc, oacc;
      st_a = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40800000};
      st_b = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F400000, 32'h33800001, 32'h3F800000};
      st_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      st_r = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h3E800000, 32'h3F800001, 32'h40A00000};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      step();
      step();
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset result", result, 32'h0);
      chk("reset flags", {28'b0, flags}, 32'h0);
      rst = 1'b0;
      #1;
      chk("reset in_ready", {31'b0, in_ready}, 32'd1);

      run_op("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      run_op("cancel",       32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
      run_op("negzero",      32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000);
      run_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
      run_op("tie_sticky",   32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
      run_op("round_carry",  32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'b0001);
      run_op("norm_left",    32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000);
      run_op("three_m_one",  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
      run_op("inf_m_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
      run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
      run_op("underflow",    32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
      run_op("nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
      run_op("inf_m_fin",    32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000);
      run_op("fin_m_inf",    32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
      run_op("zero_m_x",     32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 4'b0000);
      step();

      // Back-pressure: stall downstream, then release it every other cycle
      ni = 0; no = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (ni < 6);
         a = st_a[(ni < 6) ? ni : 0]; b = st_b[(ni < 6) ? ni : 0]; sub = st_s[(ni < 6) ? ni : 0];
         #1;
         acc = in_valid & in_ready;
         step();
         if (acc) ni++;
      end
      chk("bp accepts", ni, 32'd3);
      chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp result held", result, st_r[0]);
      cyc = 0;
      while (no < 6 && cyc < 60) begin
         out_ready = (cyc % 2 == 0);
         in_valid = (ni < 6);
         a = st_a[(ni < 6) ? ni : 0]; b = st_b[(ni < 6) ? ni : 0]; sub = st_s[(ni < 6) ? ni : 0];
         #1;
         acc  = in_valid & in_ready;
         oacc = out_valid & out_ready;
         if (oacc) got_q.push_back(result);
         step();
         if (acc) ni++;
         if (oacc) no++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp all accepted", ni, 32'd6);
      chk("bp delivered", got_q.size(), 32'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("bp order %0d", i), got_q[i], st_r[i]);
      seen = 0;
      repeat (5) begin
         if (out_valid) seen++;
         step();
      end
      chk("bp no duplicate", seen, 32'd0);

      // Reset with two operations in flight
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000; sub = 1'b0;
      step();
      a = 32'h3F800000; b = 32'h3F800000;
      step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst result", result, 32'h0);
      rst = 1'b0;
      #1;
      chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
      seen = 0;
      repeat (6) begin
         if (out_valid) seen++;
         step();
      end
      chk("midrst discarded", seen, 32'd0);
      run_op("after_rst", 32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 4'b0000);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshake on input and output.
- Next-generation replacement for the combinational add/sub unit in the floating ALU; exponent and mantissa widths are generic (binary32 default).
- Adds correct round-to-nearest-even, exception flags, canonical NaN and back-pressure.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored mantissa field width, without hidden bit (>=4)
W, 1+EXP_W+MAN_W, derived operand/result width (localparam)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  pipeline accepts operands this cycle
a  input  W  operand A {sign, exp, man}
b  input  W  operand B
sub  input  1  1: a-b, 0: a+b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  W  rounded sum/difference
flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset: rst=1 at a rising clk clears all stage valid bits. out_valid=0, result=0, flags=0 on the next edge. rst mid-operation discards every in-flight operation; none re-emerge. in_ready=1 in the first cycle after rst deasserts.
- Pipeline enable: en = !out_valid | out_ready. in_ready = en. Transfer in = in_valid & in_ready. All stages advance together when en=1 and hold when en=0; this is a global stall.
- Bubbles: empty stages carry valid=0 and are overwritten on the next advance.
- Latency: exactly 3 en-cycles. With out_ready tied to 1, throughput is one operation per cycle.
- result and flags change only when a new result is transferred out. They are stable while out_valid=1 & out_ready=0.
- Stage 1 (unpack/align):
  - Effective B sign = b.sign ^ sub.
  - Subnormal inputs (exp=0) are flushed to a signed zero.
  - Special cases are classified here and bypass the arithmetic path.
  - Operands are swapped so the larger magnitude is X.
  - Y is shifted right by (expX-expY). Shift amounts >= MAN_W+3 collapse Y into the sticky bit.
  - Datapath width is MAN_W+4: hidden bit, mantissa, guard, round, sticky.
- Stage 2 (add): add the aligned mantissas if the effective signs match, otherwise subtract (X-Y >= 0). The carry-out bit is kept. Result sign = sign of X.
- Stage 3 (normalize/round):
  - On carry-out: shift right 1, OR the lost bit into sticky, exp+1.
  - Otherwise: leading-zero count, then shift left by min(lzc, exp-1).
  - Round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalizes with exp+1.
- Exact-zero sums:
  - An exact zero magnitude gives +0.
  - -0 + -0 gives -0, and +0 - +0 gives +0.
- Overflow: final exp >= 2^EXP_W-1 gives signed infinity with overflow=1 and inexact=1.
- Underflow: normalized exp <= 0 for a nonzero result gives a signed zero (flush-to-zero) with underflow=1 and inexact=1.
- inexact=1 whenever any discarded bit is nonzero.
- Specials:
  - Any NaN input → canonical qNaN {0, all-ones exp, 1, zeros}, all flags 0 except invalid, which is set only for inf-inf.
  - inf + (-inf) → canonical qNaN with invalid=1.
  - inf op finite → that infinity (sign after sub applied), flags 0.
  - zero op x → x exactly, flags 0.

Test Plan:
- 1.0+2.0: a=0x3F800000, b=0x40000000, sub=0 → result=0x40400000, flags=0, out_valid exactly 3 cycles after accept.
- Cancellation: a=0x3F800000, b=0x3F800000, sub=1 → 0x00000000, flags=0. Also a=0x80000000, b=0x00000000, sub=1 → 0x80000000.
- Tie to even: a=0x3F800000, b=0x33800000 (2^-24), sub=0 → 0x3F800000, inexact=1. With b=0x33800001 → 0x3F800001, inexact=1.
- Specials:
  - a=0x7F800000, b=0x7F800000, sub=1 → 0x7FC00000, invalid=1.
  - a=0x7F7FFFFF, b=0x7F7FFFFF, sub=0 → 0x7F800000, overflow=1, inexact=1.
  - a=0x00800000, b=0x00800001, sub=1 → 0x80000000, underflow=1, inexact=1.
- Back-pressure: stream 6 back-to-back ops with out_ready=0 → in_ready drops after 3 accepts and result holds. Then toggle out_ready 1/0 → all 6 results delivered in order, none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert rst one cycle → out_valid=0 next cycle, neither result is ever output, and the next op completes normally at latency 3.
